// File: rtl/ld_align.sv
`default_nettype none
// ============================================================================
// Module   : ld_align
// Brief    : Load-return stage: tracks issued beats, merges split accesses,
//            extracts the addressed byte/half/word and extends it.
// Revision : 1.0  initial release
// ============================================================================

`ifndef MA_LEN_1B
`define MA_LEN_1B 2'd0
`endif
`ifndef MA_LEN_2B
`define MA_LEN_2B 2'd1
`endif
`ifndef MA_LEN_4B
`define MA_LEN_4B 2'd2
`endif

module ld_align #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        iss_load,
  input  logic        iss_second,
  input  logic [1:0]  iss_len,
  input  logic [1:0]  iss_off,
  input  logic        iss_unsigned,
  input  logic [31:0] mem_rdata,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        ld_err
);

  typedef struct packed {
    logic       sec;
    logic [1:0] len;
    logic [1:0] off;
    logic       uns;
  } beat_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  logic [RD_LAT-1:0] r_pv;
  beat_t             r_pb [RD_LAT];
  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_hold;
  logic [1:0]        r_hlen;
  logic [1:0]        r_hoff;
  logic              r_huns;

  logic              w_ret_v;
  beat_t             w_ret;
  logic              w_mis;
  logic              w_emit;
  logic              w_err;
  logic              w_hold_ld;
  logic [31:0]       w_hi;
  logic [31:0]       w_lo;
  logic [1:0]        w_len;
  logic [1:0]        w_off;
  logic              w_uns;
  logic [31:0]       w_sh;
  logic [31:0]       w_ext;

  // Valid bits need reset/flush; the attribute payload only matters where valid is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pv <= '0;
    end else if (flush) begin
      r_pv <= '0;
    end else begin
      r_pv[0] <= iss_load;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_pb[0] <= {iss_second, iss_len, iss_off, iss_unsigned};
    for (int i = 1; i < RD_LAT; i++) begin
      r_pb[i] <= r_pb[i-1];
    end
  end

  assign w_ret_v = r_pv[RD_LAT-1];
  assign w_ret   = r_pb[RD_LAT-1];
  assign w_mis   = ((w_ret.len == `MA_LEN_2B) && (w_ret.off == 2'd3)) ||
                   ((w_ret.len == `MA_LEN_4B) && (w_ret.off != 2'd0));

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_err       = 1'b0;
    w_hold_ld   = 1'b0;
    w_hi        = 32'b0;
    w_lo        = mem_rdata;
    w_len       = w_ret.len;
    w_off       = w_ret.off;
    w_uns       = w_ret.uns;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else if (w_ret_v) begin
      case (r_state)
        ST_IDLE: begin
          if (w_ret.sec) begin
            w_err = 1'b1;
          end else if (w_mis) begin
            w_hold_ld   = 1'b1;
            w_state_nxt = ST_HOLD;
          end else begin
            w_emit = 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_ret.sec) begin
            // Second beat supplies the upper word; shape comes from the first beat.
            w_emit      = 1'b1;
            w_hi        = mem_rdata;
            w_lo        = r_hold;
            w_len       = r_hlen;
            w_off       = r_hoff;
            w_uns       = r_huns;
            w_state_nxt = ST_IDLE;
          end else begin
            w_err     = 1'b1;
            w_hold_ld = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_sh = 32'({w_hi, w_lo} >> {w_off, 3'b000});
    case (w_len)
      `MA_LEN_1B: w_ext = {{24{~w_uns & w_sh[7]}}, w_sh[7:0]};
      `MA_LEN_2B: w_ext = {{16{~w_uns & w_sh[15]}}, w_sh[15:0]};
      default:    w_ext = w_sh;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_valid <= 1'b0;
      ld_err   <= 1'b0;
      ld_data  <= 32'b0;
      r_state  <= ST_IDLE;
      r_hold   <= 32'b0;
      r_hlen   <= 2'b0;
      r_hoff   <= 2'b0;
      r_huns   <= 1'b0;
    end else begin
      ld_valid <= w_emit;
      ld_err   <= w_err;
      r_state  <= w_state_nxt;
      if (w_emit) begin
        ld_data <= w_ext;
      end
      if (w_hold_ld) begin
        r_hold <= mem_rdata;
        r_hlen <= w_ret.len;
        r_hoff <= w_ret.off;
        r_huns <= w_ret.uns;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ld_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_ld_align
// Brief    : Randomised bench for ld_align at RD_LAT=1 and RD_LAT=3 against a
//            return-schedule model, plus literal anchor cases.
// Revision : 1.0  initial release
// ============================================================================

`ifndef MA_LEN_1B
`define MA_LEN_1B 2'd0
`endif
`ifndef MA_LEN_2B
`define MA_LEN_2B 2'd1
`endif
`ifndef MA_LEN_4B
`define MA_LEN_4B 2'd2
`endif

module tb_ld_align;

  localparam int c_nw = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        iss_load = 1'b0;
  logic        iss_second = 1'b0;
  logic [1:0]  iss_len = 2'd0;
  logic [1:0]  iss_off = 2'd0;
  logic        iss_unsigned = 1'b0;
  int          iss_waddr = 0;
  logic [31:0] mem_rdata1 = 32'b0;
  logic [31:0] mem_rdata3 = 32'b0;
  logic        ld_valid1, ld_err1, ld_valid3, ld_err3;
  logic [31:0] ld_data1, ld_data3;

  logic [31:0] mem [c_nw];
  bit          hist_v [8];
  int          hist_a [8];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  ld_align #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .iss_load(iss_load), .iss_second(iss_second),
    .iss_len(iss_len), .iss_off(iss_off), .iss_unsigned(iss_unsigned), .mem_rdata(mem_rdata1),
    .ld_valid(ld_valid1), .ld_data(ld_data1), .ld_err(ld_err1)
  );

  ld_align #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .flush(flush), .iss_load(iss_load), .iss_second(iss_second),
    .iss_len(iss_len), .iss_off(iss_off), .iss_unsigned(iss_unsigned), .mem_rdata(mem_rdata3),
    .ld_valid(ld_valid3), .ld_data(ld_data3), .ld_err(ld_err3)
  );

  // Byte-level view: pick consecutive bytes out of {hi, lo} and extend.
  function automatic logic [31:0] extract(input logic [31:0] hi, input logic [31:0] lo,
                                          input logic [1:0] len, input logic [1:0] off,
                                          input logic uns);
    logic [7:0]  b [8];
    logic [31:0] v;
    int          n;
    int          base;
    for (int i = 0; i < 4; i++) begin
      b[i]   = lo[8*i +: 8];
      b[i+4] = hi[8*i +: 8];
    end
    n    = (len == `MA_LEN_1B) ? 1 : (len == `MA_LEN_2B) ? 2 : 4;
    base = int'(off);
    v    = 32'b0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = b[base+i];
    if (!uns && n < 4 && v[8*n-1]) begin
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  function automatic bit misal(input logic [1:0] len, input logic [1:0] off);
    return (len == `MA_LEN_2B && off == 2'd3) || (len == `MA_LEN_4B && off != 2'd0);
  endfunction

  // Reference model: returns scheduled by due cycle, plus one held first beat.
  typedef struct {
    bit         v;
    bit         sec;
    logic [1:0] len;
    logic [1:0] off;
    bit         uns;
    int         waddr;
  } slot_t;

  slot_t       slot [2][8];
  int          lat [2] = '{1, 3};
  bit          hold_v [2];
  logic [31:0] hold_w [2];
  logic [1:0]  hold_len [2];
  logic [1:0]  hold_off [2];
  bit          hold_uns [2];
  bit          exp_v [2];
  bit          exp_e [2];
  logic [31:0] exp_d [2];

  always @(posedge clk) begin
    slot_t       s;
    logic [31:0] word;
    int          due;
    for (int k = 0; k < 2; k++) begin
      exp_v[k] = 1'b0;
      exp_e[k] = 1'b0;
      if (rst || flush) begin
        for (int j = 0; j < 8; j++) slot[k][j].v = 1'b0;
        hold_v[k] = 1'b0;
        if (rst) exp_d[k] = 32'b0;
      end else begin
        s = slot[k][cyc % 8];
        slot[k][cyc % 8].v = 1'b0;
        if (s.v) begin
          word = mem[s.waddr];
          if (!hold_v[k]) begin
            if (s.sec) begin
              exp_e[k] = 1'b1;
            end else if (misal(s.len, s.off)) begin
              hold_v[k] = 1'b1;   hold_w[k] = word;
              hold_len[k] = s.len; hold_off[k] = s.off; hold_uns[k] = s.uns;
            end else begin
              exp_v[k] = 1'b1;
              exp_d[k] = extract(32'b0, word, s.len, s.off, s.uns);
            end
          end else if (s.sec) begin
            exp_v[k]  = 1'b1;
            exp_d[k]  = extract(word, hold_w[k], hold_len[k], hold_off[k], hold_uns[k]);
            hold_v[k] = 1'b0;
          end else begin
            exp_e[k] = 1'b1;
            hold_w[k] = word;
            hold_len[k] = s.len; hold_off[k] = s.off; hold_uns[k] = s.uns;
          end
        end
        if (iss_load) begin
          due = (cyc + lat[k]) % 8;
          slot[k][due].v     = 1'b1;
          slot[k][due].sec   = iss_second;
          slot[k][due].len   = iss_len;
          slot[k][due].off   = iss_off;
          slot[k][due].uns   = iss_unsigned;
          slot[k][due].waddr = iss_waddr;
        end
      end
    end
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic compare_all();
    check("u1.ld_valid", 32'(ld_valid1), 32'(exp_v[0]));
    check("u1.ld_err",   32'(ld_err1),   32'(exp_e[0]));
    check("u1.ld_data",  ld_data1,       exp_d[0]);
    check("u3.ld_valid", 32'(ld_valid3), 32'(exp_v[1]));
    check("u3.ld_err",   32'(ld_err3),   32'(exp_e[1]));
    check("u3.ld_data",  ld_data3,       exp_d[1]);
  endtask

  // Drive memory for this cycle, compare mid-cycle, advance to just after the next edge.
  task automatic cyc_go();
    hist_v[cyc % 8] = iss_load;
    hist_a[cyc % 8] = iss_waddr;
    mem_rdata1 = hist_v[(cyc + 7) % 8] ? mem[hist_a[(cyc + 7) % 8]] : $urandom;
    mem_rdata3 = hist_v[(cyc + 5) % 8] ? mem[hist_a[(cyc + 5) % 8]] : $urandom;
    @(negedge clk);
    if (!rst) compare_all();
    @(posedge clk);
    #1;
    iss_load   = 1'b0;
    iss_second = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_go();
  endtask

  task automatic issue(input int wa, input logic [1:0] off, input logic [1:0] len,
                       input logic uns, input logic sec);
    iss_load     = 1'b1;
    iss_waddr    = wa;
    iss_off      = off;
    iss_len      = len;
    iss_unsigned = uns;
    iss_second   = sec;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc_go();
    rst = 1'b0;
  endtask

  initial begin
    int         wa;
    logic [1:0] off, len;
    logic       uns;
    int         r;

    for (int i = 0; i < c_nw; i++) mem[i] = $urandom;
    mem[64] = 32'h44332211;
    mem[65] = 32'h88776655;

    check("model LW 0x101",  extract(32'h88776655, 32'h44332211, `MA_LEN_4B, 2'd1, 1'b0), 32'h55443322);
    check("model LH 0x103",  extract(32'h88776655, 32'h44332211, `MA_LEN_2B, 2'd3, 1'b0), 32'h00005544);
    check("model LH 0x106",  extract(32'h0, 32'h88776655, `MA_LEN_2B, 2'd2, 1'b0), 32'hFFFF8877);
    check("model LHU 0x106", extract(32'h0, 32'h88776655, `MA_LEN_2B, 2'd2, 1'b1), 32'h00008877);
    check("model LB 0x107",  extract(32'h0, 32'h88776655, `MA_LEN_1B, 2'd3, 1'b0), 32'hFFFFFF88);
    check("model LBU 0x107", extract(32'h0, 32'h88776655, `MA_LEN_1B, 2'd3, 1'b1), 32'h00000088);
    check("model LB 0x103",  extract(32'h0, 32'h44332211, `MA_LEN_1B, 2'd3, 1'b0), 32'h00000044);

    idle(2);
    rst = 1'b0;
    check("reset ld_valid", 32'(ld_valid1), 32'h0);
    check("reset ld_err",   32'(ld_err1),   32'h0);
    check("reset ld_data",  ld_data1,       32'h0);
    idle(2);

    // Back-to-back LW 0x100, LW 0x104
    issue(64, 2'd0, `MA_LEN_4B, 1'b0, 1'b0); cyc_go();
    check("b2b u1 c1 valid", 32'(ld_valid1), 32'h0);
    issue(65, 2'd0, `MA_LEN_4B, 1'b0, 1'b0); cyc_go();
    check("b2b u1 c2 valid", 32'(ld_valid1), 32'h1);
    check("b2b u1 c2 data",  ld_data1, 32'h44332211);
    cyc_go();
    check("b2b u1 c3 data",  ld_data1, 32'h88776655);
    cyc_go();
    check("b2b u3 c4 valid", 32'(ld_valid3), 32'h1);
    check("b2b u3 c4 data",  ld_data3, 32'h44332211);
    cyc_go();
    check("b2b u3 c5 valid", 32'(ld_valid3), 32'h1);
    check("b2b u3 c5 data",  ld_data3, 32'h88776655);
    idle(3);

    // Split LW 0x101
    issue(64, 2'd1, `MA_LEN_4B, 1'b0, 1'b0); cyc_go();
    issue(65, 2'd1, `MA_LEN_4B, 1'b0, 1'b1); cyc_go();
    check("split u1 c2 valid", 32'(ld_valid1), 32'h0);
    cyc_go();
    check("split u1 c3 valid", 32'(ld_valid1), 32'h1);
    check("split u1 c3 data",  ld_data1, 32'h55443322);
    idle(2);
    check("split u3 c5 valid", 32'(ld_valid3), 32'h1);
    check("split u3 c5 data",  ld_data3, 32'h55443322);
    idle(2);

    // LH 0x106 signed
    issue(65, 2'd2, `MA_LEN_2B, 1'b0, 1'b0); idle(2);
    check("LH 0x106 data", ld_data1, 32'hFFFF8877);
    idle(3);

    // Reset between beats of LW 0x102, then stray second
    issue(64, 2'd2, `MA_LEN_4B, 1'b0, 1'b0); idle(2);
    do_reset();
    idle(1);
    issue(65, 2'd2, `MA_LEN_4B, 1'b0, 1'b1); idle(2);
    check("rst stray err",   32'(ld_err1),   32'h1);
    check("rst stray valid", 32'(ld_valid1), 32'h0);
    idle(3);

    // Flush between beats of LW 0x102, second issued after flush
    issue(64, 2'd2, `MA_LEN_4B, 1'b0, 1'b0); idle(2);
    flush = 1'b1; cyc_go();
    issue(65, 2'd2, `MA_LEN_4B, 1'b0, 1'b1); idle(2);
    check("flush stray err",   32'(ld_err1),   32'h1);
    check("flush stray valid", 32'(ld_valid1), 32'h0);
    idle(4);

    for (int n = 0; n < 500; n++) begin
      r = int'($urandom_range(0, 24));
      if (r == 0) begin
        do_reset();
      end else if (r == 1) begin
        issue(int'($urandom_range(0, c_nw - 1)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b1);
        cyc_go();
      end else if (r == 2) begin
        flush = 1'b1;
        if ($urandom_range(0, 1) == 1)
          issue(int'($urandom_range(0, c_nw - 2)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);
        cyc_go();
      end else begin
        wa  = int'($urandom_range(0, c_nw - 2));
        off = 2'($urandom_range(0, 3));
        len = 2'($urandom_range(0, 2));
        uns = 1'($urandom_range(0, 1));
        issue(wa, off, len, uns, 1'b0);
        cyc_go();
        if (misal(len, off)) begin
          idle(int'($urandom_range(0, 3)));
          // Attributes on the second beat are deliberately scrambled.
          issue(wa + 1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), 1'b1);
          cyc_go();
        end
      end
      idle(int'($urandom_range(0, 2)));
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
